// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
//   XLEN        machine word width in bits
//   WORD_BYTES  bytes per instruction word (fetch PC stride)
//   INST_NOP    word presented when no instruction is available
//   fetch_state_t  instruction-fetch sequencer states
//   align_word  clears the byte-offset bits of an address
package mips_pkg;

    localparam int XLEN       = 32;
    localparam int WORD_BYTES = 4;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    // Masking keeps every address bit in use, so callers need not slice.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read.
//   clk        clock, all updates on posedge
//   rst        synchronous active-high reset (control state only)
//   clear      synchronous flush; wins over push and pop
//   push       write push_data at the tail (dropped only if full without pop)
//   push_data  DATA_W-bit entry
//   pop        remove head (ignored when empty)
//   pop_data   current head entry (undefined when empty)
//   full       DEPTH entries stored
//   empty      no entries stored
//   count      number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    assign pop_data = mem[rd_ptr];

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only and is never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Decoupled instruction-fetch front end.
// Owns the fetch PC, issues one word request at a time to instruction memory,
// queues returned words with their PCs, and hands them to decode over
// valid/ready. A redirect flushes the queue and restarts fetch at the target.
//   clk          clock
//   reset        synchronous active-high reset
//   redirect     taken branch/jump this cycle (highest priority)
//   redirect_pc  branch/jump target; low two bits ignored
//   imem_req     fetch request valid
//   imem_addr    word-aligned fetch address (equals fetch PC)
//   imem_ready   memory accepts the request this cycle
//   imem_rvalid  read data valid
//   imem_rdata   returned instruction word
//   inst_valid   queue head valid
//   instruction  head instruction, zero when empty
//   inst_pc      head PC, zero when empty
//   inst_ready   consumer takes the head this cycle
module ifetch_queue
    import mips_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;

    logic              q_push;
    logic              q_pop;
    logic              q_clear;
    logic [2*XLEN-1:0] q_head;
    logic              q_full;
    logic              q_empty;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W-1:0]  in_flight;
    logic              credit_ok;
    logic              accept;

    // An outstanding request already owns a slot, so it counts against space.
    assign in_flight = CNT_W'(state_q == WAIT);
    assign credit_ok = !q_full && ((q_count + in_flight) < CNT_W'(DEPTH));

    // Gating with reset keeps the request low while reset is held.
    assign imem_req  = (state_q == IDLE) && credit_ok && !redirect && !reset;
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_ready;

    // A redirect empties the queue, so a same-cycle pop is meaningless.
    assign q_clear = redirect;
    assign q_pop   = inst_ready && !q_empty && !redirect;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        q_push     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + XLEN'(WORD_BYTES);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid && !redirect) begin
                    q_push  = 1'b1;
                    state_d = IDLE;
                end else if (redirect && !imem_rvalid) begin
                    // The response for the old path is still coming; swallow it.
                    state_d = DROP;
                end else if (redirect && imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides any fetch-PC advance; accept cannot coincide with it.
        if (redirect) begin
            fetch_pc_d = align_word(redirect_pc);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Request PC is data that is only read after being written on accept.
    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
    end

    sync_fifo #(
        .DATA_W (2 * XLEN),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (reset),
        .clear     (q_clear),
        .push      (q_push),
        .push_data ({req_pc_q, imem_rdata}),
        .pop       (q_pop),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign inst_valid  = !q_empty;
    assign instruction = q_empty ? INST_NOP : q_head[XLEN-1:0];
    assign inst_pc     = q_empty ? '0 : q_head[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: fetch ordering, credit limit, redirect
// flush/drop behaviour, PC wrap and mid-transaction reset.
module tb_ifetch_queue;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int checks;
    int errors;
    int acc_cnt;
    bit auto_resp;

    ifetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .instruction (instruction),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample the accept at negedge, then after the edge drive the
    // memory response (one cycle after accept) when auto_resp is on.
    task automatic tick();
        logic        a;
        logic [31:0] ad;
        @(negedge clk);
        a  = imem_req && imem_ready;
        ad = imem_addr;
        if (a) acc_cnt++;
        @(posedge clk);
        #1;
        if (auto_resp && a) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(ad);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
    endtask

    initial begin
        int          nreq;
        logic [31:0] addrs [8];
        logic [31:0] exp_pc;

        checks      = 0;
        errors      = 0;
        acc_cnt     = 0;
        auto_resp   = 1'b1;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        inst_ready  = 1'b0;
        nreq        = 0;
        for (int i = 0; i < 8; i++) addrs[i] = 32'h0;

        tick();
        tick();
        chk("rst_req",   {31'b0, imem_req},   32'h0);
        chk("rst_addr",  imem_addr,           32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_inst",  instruction,         32'h0);
        chk("rst_pc",    inst_pc,             32'h0);

        // Fill with the consumer stalled: exactly four requests 0,4,8,C.
        reset   = 1'b0;
        acc_cnt = 0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_ready) begin
                if (nreq < 8) addrs[nreq] = imem_addr;
                nreq++;
            end
            tick();
        end
        chk("fill_nreq",  nreq,     32'd4);
        chk("fill_a0",    addrs[0], 32'h0);
        chk("fill_a1",    addrs[1], 32'h4);
        chk("fill_a2",    addrs[2], 32'h8);
        chk("fill_a3",    addrs[3], 32'hC);
        chk("full_req",   {31'b0, imem_req},   32'h0);
        chk("full_valid", {31'b0, inst_valid}, 32'h1);

        // Drain continuously: heads must appear in PC order with their words.
        inst_ready = 1'b1;
        exp_pc     = 32'h0;
        #1;
        for (int i = 0; i < 24; i++) begin
            if (inst_valid) begin
                chk("flow_pc",   inst_pc,     exp_pc);
                chk("flow_inst", instruction, mem_word(exp_pc));
                exp_pc = exp_pc + 32'h4;
            end
            tick();
        end
        chk("flow_pops_min", {31'b0, (exp_pc >= 32'h20)}, 32'h1);

        // Stop the memory and let everything drain out.
        imem_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        inst_ready = 1'b0;
        #1;
        chk("empty_valid", {31'b0, inst_valid}, 32'h0);
        chk("empty_inst",  instruction,         32'h0);
        chk("empty_pc",    inst_pc,             32'h0);
        chk("stall_req",   {31'b0, imem_req},   32'h1);
        chk("stall_addr0", imem_addr,           acc_cnt * 4);
        tick();
        chk("stall_addr1", imem_addr,           acc_cnt * 4);

        // Redirect while WAIT, response arrives three cycles later and is dropped.
        auto_resp  = 1'b0;
        imem_ready = 1'b1;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0043;
        #1;
        chk("rd_wait_req", {31'b0, imem_req}, 32'h0);
        tick();
        redirect = 1'b0;
        #1;
        chk("drop_req",   {31'b0, imem_req},   32'h0);
        chk("drop_valid", {31'b0, inst_valid}, 32'h0);
        tick();
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("drop_rv_req", {31'b0, imem_req}, 32'h0);
        tick();
        chk("rd_req",   {31'b0, imem_req},   32'h1);
        chk("rd_addr",  imem_addr,           32'h0000_0040);
        chk("rd_valid", {31'b0, inst_valid}, 32'h0);
        auto_resp = 1'b1;
        tick();
        tick();
        chk("rd_head_pc",   inst_pc,     32'h0000_0040);
        chk("rd_head_inst", instruction, mem_word(32'h0000_0040));

        // Redirect, pop and rvalid all in one cycle.
        auto_resp = 1'b0;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        inst_ready  = 1'b1;
        #1;
        chk("tri_pre_pc", inst_pc, 32'h0000_0040);
        tick();
        redirect   = 1'b0;
        inst_ready = 1'b0;
        auto_resp  = 1'b1;
        #1;
        chk("tri_valid", {31'b0, inst_valid}, 32'h0);
        chk("tri_pc",    inst_pc,             32'h0);
        chk("tri_inst",  instruction,         32'h0);
        chk("tri_req",   {31'b0, imem_req},   32'h1);
        chk("tri_addr",  imem_addr,           32'h0000_0200);
        tick();
        tick();
        chk("tri_head_pc",   inst_pc,     32'h0000_0200);
        chk("tri_head_inst", instruction, mem_word(32'h0000_0200));

        // Redirect to the top word; fetch must wrap to zero.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap_rd_req", {31'b0, imem_req}, 32'h0);
        tick();
        redirect = 1'b0;
        #1;
        chk("wrap_addr0", imem_addr,           32'hFFFF_FFFC);
        chk("wrap_req0",  {31'b0, imem_req},   32'h1);
        chk("wrap_flush", {31'b0, inst_valid}, 32'h0);
        tick();
        tick();
        chk("wrap_head_pc", inst_pc,   32'hFFFF_FFFC);
        chk("wrap_addr1",   imem_addr, 32'h0000_0000);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tick();
        chk("wrap_head2_pc",   inst_pc,     32'h0000_0000);
        chk("wrap_head2_inst", instruction, mem_word(32'h0000_0000));

        // Reset while a response is outstanding.
        auto_resp = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_req",   {31'b0, imem_req},   32'h0);
        chk("mid_rst_addr",  imem_addr,           32'h0);
        chk("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("mid_rst_inst",  instruction,         32'h0);
        chk("mid_rst_pc",    inst_pc,             32'h0);
        reset     = 1'b0;
        auto_resp = 1'b1;
        #1;
        chk("post_rst_req",  {31'b0, imem_req}, 32'h1);
        chk("post_rst_addr", imem_addr,         32'h0);
        tick();
        tick();
        chk("post_rst_pc",   inst_pc,     32'h0);
        chk("post_rst_inst", instruction, mem_word(32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
